// File: rtl/acionador_ventilador.sv
// Fan actuator driver: filters the s1/s2 command pair, ramps duty, drives PWM.
// Ports: clk, rst (async, active high), s1, s2 -> pwm, duty, estado, pronto.
module acionador_ventilador #(
  parameter int PWM_BITS  = 8,
  parameter int LOW_DUTY  = 128,
  parameter int HIGH_DUTY = 255,
  parameter int STEP      = 16,
  parameter int RAMP_DIV  = 4,
  parameter int STABLE    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s1,
  input  logic                s2,
  output logic                pwm,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          estado,
  output logic                pronto
);

  localparam int DW = PWM_BITS + 1;
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int SW = $clog2(STABLE + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(RAMP_DIV - 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE);
  localparam logic [SW-1:0] STAB_ONE  = SW'(1);

  localparam logic [DW-1:0]       STEP_X = DW'(STEP);
  localparam logic [PWM_BITS-1:0] STEP_N = PWM_BITS'(STEP);
  localparam logic [PWM_BITS-1:0] LOW_N  = PWM_BITS'(LOW_DUTY);
  localparam logic [PWM_BITS-1:0] HIGH_N = PWM_BITS'(HIGH_DUTY);

  localparam logic [1:0] PARADO   = 2'b00;
  localparam logic [1:0] SUBINDO  = 2'b01;
  localparam logic [1:0] DESCENDO = 2'b10;
  localparam logic [1:0] ESTAVEL  = 2'b11;

  logic [1:0]          meta_q, meta_d;
  logic [1:0]          sync_q, sync_d;
  logic [1:0]          cand_q, cand_d;
  logic [SW-1:0]       stab_q, stab_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] ativo_q, ativo_d;
  logic                pwm_q, pwm_d;

  logic [PWM_BITS-1:0] alvo;
  logic [DW-1:0]       duty_x, alvo_x;
  logic [DW-1:0]       up_x, dn_lim_x;
  logic                tick;

  always_comb begin
    meta_d = {s1, s2};
    sync_d = meta_q;
  end

  // stab counts consecutive samples equal to the candidate,
  // the sample that reloads the candidate counting as the first
  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    cmd_d  = cmd_q;
    if (sync_q != cand_q) begin
      cand_d = sync_q;
      stab_d = STAB_ONE;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 1'b1;
    end
    if (stab_d == STAB_MAX) begin
      cmd_d = cand_d;
    end
  end

  always_comb begin
    alvo = '0;
    unique case (1'b1)
      (cmd_q == 2'b00): alvo = '0;
      (cmd_q == 2'b11): alvo = HIGH_N;
      default:          alvo = LOW_N;
    endcase
  end

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // widened compares keep the step from wrapping or overshooting
  always_comb begin
    duty_x   = {1'b0, duty_q};
    alvo_x   = {1'b0, alvo};
    up_x     = duty_x + STEP_X;
    dn_lim_x = alvo_x + STEP_X;
    duty_d   = duty_q;
    if (tick) begin
      if (duty_x < alvo_x) begin
        if (up_x > alvo_x) duty_d = alvo;
        else               duty_d = duty_q + STEP_N;
      end else if (duty_x > alvo_x) begin
        if (duty_x > dn_lim_x) duty_d = duty_q - STEP_N;
        else                   duty_d = alvo;
      end
    end
  end

  always_comb begin
    estado = PARADO;
    unique case (1'b1)
      (duty_q < alvo): estado = SUBINDO;
      (duty_q > alvo): estado = DESCENDO;
      default: estado = (alvo == '0) ? PARADO : ESTAVEL;
    endcase
    pronto = (estado == PARADO) || (estado == ESTAVEL);
  end

  // duty is sampled at the period boundary so a pulse is never cut
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    ativo_d = (&cnt_q) ? duty_q : ativo_q;
    pwm_d   = (cnt_q < ativo_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= '0;
      sync_q  <= '0;
      cand_q  <= '0;
      stab_q  <= '0;
      cmd_q   <= '0;
      presc_q <= '0;
      duty_q  <= '0;
      cnt_q   <= '0;
      ativo_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      cmd_q   <= cmd_d;
      presc_q <= presc_d;
      duty_q  <= duty_d;
      cnt_q   <= cnt_d;
      ativo_q <= ativo_d;
      pwm_q   <= pwm_d;
    end
  end

  assign duty = duty_q;
  assign pwm  = pwm_q;

endmodule

// File: tb/tb_acionador_ventilador.sv
// Bench for acionador_ventilador: random command stream against
// a behavioural model built from command history and tick arithmetic.
module tb_acionador_ventilador;

  localparam int PB   = 8;
  localparam int LOW  = 128;
  localparam int HIGH = 255;
  localparam int STP  = 16;
  localparam int RD   = 4;
  localparam int ST   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          s1, s2;
  logic          pwm;
  logic [PB-1:0] duty;
  logic [1:0]    estado;
  logic          pronto;

  acionador_ventilador #(
    .PWM_BITS (PB),
    .LOW_DUTY (LOW),
    .HIGH_DUTY(HIGH),
    .STEP     (STP),
    .RAMP_DIV (RD),
    .STABLE   (ST)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s1    (s1),
    .s2    (s2),
    .pwm   (pwm),
    .duty  (duty),
    .estado(estado),
    .pronto(pronto)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int k;
  int hist[$];
  int m_cmd, m_duty, m_ativo, m_pwm;

  task automatic chk(string tag, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int in_at(int e);
    if (e < 1) return 0;
    return hist[e-1];
  endfunction

  function automatic int alvo_of(int c);
    if (c == 0) return 0;
    if (c == 3) return HIGH;
    return LOW;
  endfunction

  function automatic int estado_of(int d, int a);
    if (d < a) return 1;
    if (d > a) return 2;
    return (a == 0) ? 0 : 3;
  endfunction

  task automatic model_reset();
    k = 0;
    hist.delete();
    m_cmd   = 0;
    m_duty  = 0;
    m_ativo = 0;
    m_pwm   = 0;
  endtask

  task automatic cyc();
    int a, cb, v, e;
    bit ok;
    @(posedge clk);
    k++;
    hist.push_back(int'({s1, s2}));
    a  = alvo_of(m_cmd);
    cb = (k - 1) % 256;
    m_pwm = (cb < m_ativo) ? 1 : 0;
    if (cb == 255) m_ativo = m_duty;
    if (k % RD == 0) begin
      if (m_duty < a)
        m_duty = (m_duty + STP > a) ? a : m_duty + STP;
      else if (m_duty > a)
        m_duty = (m_duty - STP < a) ? a : m_duty - STP;
    end
    v  = in_at(k - 2);
    ok = 1'b1;
    for (int j = 3; j <= ST + 1; j++)
      if (in_at(k - j) != v) ok = 1'b0;
    if (ok) m_cmd = v;
    @(negedge clk);
    e = estado_of(m_duty, alvo_of(m_cmd));
    chk("duty", int'(duty), m_duty);
    chk("estado", int'(estado), e);
    chk("pronto", int'(pronto), (e == 0 || e == 3) ? 1 : 0);
    chk("pwm", int'(pwm), m_pwm);
  endtask

  task automatic run(int v, int n);
    s1 = v[1];
    s2 = v[0];
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_estado", int'(estado), 0);
    chk("rst_pronto", int'(pronto), 1);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_duty", int'(duty), 0);
      chk("rst_hold_pwm", int'(pwm), 0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int hi, v, n;
    rst = 1'b1;
    s1  = 1'b0;
    s2  = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    chk("init_pwm", int'(pwm), 0);
    chk("init_duty", int'(duty), 0);
    chk("init_estado", int'(estado), 0);
    chk("init_pronto", int'(pronto), 1);
    @(negedge clk);
    rst = 1'b0;

    run(0, 10);
    run(2, 60);
    chk("soft_start_end", int'(duty), LOW);
    run(3, 60);
    chk("saturate", int'(duty), HIGH);
    run(0, 140);
    chk("stop_end", int'(duty), 0);

    run(1, 2);
    run(0, 30);
    chk("glitch_duty", int'(duty), 0);
    run(1, 3);
    run(0, 80);

    s1 = 1'b1;
    s2 = 1'b0;
    for (int i = 0; i < 200 && m_duty != 64; i++) cyc();
    chk("reach_64", int'(duty), 64);
    run(0, 100);
    chk("reversal_end", int'(duty), 0);

    run(2, 600);
    hi = 0;
    repeat (256) begin
      cyc();
      hi += int'(pwm);
    end
    chk("pwm_period", hi, 128);

    run(0, 200);
    s1 = 1'b1;
    for (int i = 0; i < 200 && m_duty != 96; i++) cyc();
    chk("reach_96", int'(duty), 96);
    do_reset();
    run(2, 60);

    repeat (150) begin
      v = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) n = int'($urandom_range(1, 4));
      else n = int'($urandom_range(5, 120));
      run(v, n);
      if ($urandom_range(0, 39) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
